// File: rtl/slice_fb_writer.sv
// slice_fb_writer: writes front-end pixels into a two-bank ping-pong slice RAM and hands finished banks to the LED driver.
// Latency: pixel_valid -> ram_we/ram_waddr/ram_wdata 1 cycle; EOS rising edge -> slice_ready/bank_full 1 cycle.
// Backpressure: none; while the other bank is still owned by the driver, whole slices are dropped (SLICE_FB_WRITER_STATS_EN builds drop_cnt).
module slice_fb_writer #(
   parameter int BANKS_LOG2   = 1,
   parameter int SLICE_PIXELS = 1920
) (
   input  logic                                       clk,
   input  logic                                       nrst,
   input  logic [23:0]                                pixel_data,
   input  logic                                       pixel_valid,
   input  logic [2:0]                                 pixel_col,
   input  logic [3:0]                                 pixel_line,
   input  logic [2:0]                                 block_col,
   input  logic [1:0]                                 block_line,
   input  logic                                       EOS,
   input  logic [6:0]                                 wslice_cnt,
   output logic                                       ram_we,
   output logic [BANKS_LOG2+$clog2(SLICE_PIXELS)-1:0] ram_waddr,
   output logic [23:0]                                ram_wdata,
   input  logic                                       release_valid,
   input  logic                                       release_bank,
   output logic                                       slice_ready,
   output logic                                       ready_bank,
   output logic [6:0]                                 ready_slice,
   output logic [1:0]                                 bank_full,
   output logic                                       overflow,
   output logic [7:0]                                 drop_cnt
);

   typedef enum logic {WRITE, DROP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        wr_bank;
   logic        wr_bank_nxt;
   logic        eos_r;
   logic        eos_edge;
   logic        other_free;
   logic        write_en;
   logic [1:0]  rel_mask;
   logic [1:0]  set_mask;
   logic [1:0]  full_rel;
   logic [3:0]  blk_idx;
   logic [10:0] offset;

   // µblock index 0..14; the in-block line/column fill the low 7 bits, so no multiplier by 128 is needed
   assign blk_idx = ({2'b00, block_line} * 4'd5) + {1'b0, block_col};
   assign offset  = {blk_idx, pixel_line, pixel_col};

   // A level held on EOS counts only once
   assign eos_edge = EOS & ~eos_r;

   // Same-cycle release is applied before the switch test
   assign rel_mask   = release_valid ? (2'b01 << release_bank) : 2'b00;
   assign full_rel   = bank_full & ~rel_mask;
   assign other_free = ~full_rel[~wr_bank];

   // Only a slice that was being written claims its bank; a dropped partial slice claims nothing
   assign set_mask = (eos_edge && state == WRITE) ? (2'b01 << wr_bank) : 2'b00;

   // Both WRITE and DROP switch to the other bank on an EOS edge when it is free, otherwise drop
   assign state_nxt   = eos_edge ? (other_free ? WRITE : DROP) : state;
   assign wr_bank_nxt = wr_bank ^ (eos_edge & other_free);

   // A pixel coinciding with the EOS edge belongs to the new slice
   assign write_en = pixel_valid & (state_nxt == WRITE);

   // Bank ownership FSM with registered RAM write port and ready handshake
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= WRITE;
         wr_bank     <= 1'b0;
         eos_r       <= 1'b0;
         bank_full   <= 2'b00;
         ram_we      <= 1'b0;
         ram_waddr   <= '0;
         ram_wdata   <= 24'd0;
         slice_ready <= 1'b0;
         ready_bank  <= 1'b0;
         ready_slice <= 7'd0;
         overflow    <= 1'b0;
      end else begin
         eos_r       <= EOS;
         state       <= state_nxt;
         wr_bank     <= wr_bank_nxt;
         bank_full   <= full_rel | set_mask;
         ram_we      <= write_en;
         slice_ready <= 1'b0;
         if (write_en) begin
            ram_waddr <= {wr_bank_nxt, offset};
            ram_wdata <= pixel_data;
         end
         case (state)
            WRITE: begin
               if (eos_edge) begin
                  slice_ready <= 1'b1;
                  ready_bank  <= wr_bank;
                  ready_slice <= wslice_cnt - 7'd1;
               end
            end
            DROP: begin
               if (eos_edge) begin
                  overflow <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SLICE_FB_WRITER_STATS_EN
   // Saturating count of EOS edges seen while dropping
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         drop_cnt <= 8'd0;
      end else if (eos_edge && state == DROP && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`else
   assign drop_cnt = 8'd0;
`endif

endmodule

// File: doc/slice_fb_writer.md
# slice_fb_writer

Sink stage directly downstream of the RGB pixel front-end. It takes each valid pixel and its µblock coordinates and writes the pixel into a double-buffered (ping-pong) slice RAM. It swaps banks on end-of-slice and hands each completed bank to the LED-driver side. It also holds off overwriting a bank the driver has not yet released, dropping whole slices when it must.

## Interface

Parameters:
- `BANKS_LOG2`, 1: bank-select address bits. The value is fixed at 1; this is a two-bank ping-pong.
- `SLICE_PIXELS`, 1920: pixels per slice (3×5 µblocks × 16 lines × 8 columns).

Ports:
- `clk`, input, 1: system clock.
- `nrst`, input, 1: asynchronous, active-low reset.
- `pixel_data`, input, 24: pixel from the front-end.
- `pixel_valid`, input, 1: pixel qualifier.
- `pixel_col`, input, 3: column in µblock, 0..7.
- `pixel_line`, input, 4: line in µblock, 0..15.
- `block_col`, input, 3: µblock column, 0..4.
- `block_line`, input, 2: µblock line, 0..2.
- `EOS`, input, 1: end of slice. It can stay high for more than one cycle.
- `wslice_cnt`, input, 7: slice counter. It has already incremented when `EOS` rises.
- `ram_we`, output, 1: RAM write enable.
- `ram_waddr`, output, 12: RAM address, {bank, 11-bit offset}.
- `ram_wdata`, output, 24: RAM write data.
- `release_valid`, input, 1: the driver frees a bank (1-cycle pulse).
- `release_bank`, input, 1: the bank being freed.
- `slice_ready`, output, 1: 1-cycle pulse; a bank holds a complete slice.
- `ready_bank`, output, 1: bank completed; held until the next pulse.
- `ready_slice`, output, 7: slice number of that bank; held until the next pulse.
- `bank_full`, output, 2: per-bank ownership flags. 1 means the bank is owned by the driver.
- `overflow`, output, 1: sticky. Set on the first dropped slice, cleared only by reset.
- `drop_cnt`, output, 8: dropped-slice count (see Configuration).

## Operation

Address:
- offset = ((block_line·5 + block_col)·16 + pixel_line)·8 + pixel_col. The range is 0..1919; 11 bits, no wrap.
- Coordinates above their range (for example `block_col` = 5) are not checked. Verification never drives them.

Pixel writes:
- A write occurs when `pixel_valid` = 1 and the state is WRITE.
- Write bank = `wr_bank`, as it is after any switch decided in the same cycle.

EOS handling:
- Act only on the rising edge of `EOS` (registered `EOS_r`). A level held across FIFO-empty cycles counts as one event.

Release handling:
- `release_valid` clears `bank_full[release_bank]`.
- A release arriving in the same cycle as an EOS edge is applied before the switch test.
- Releasing a bank that is not full is a no-op.

State machine (states WRITE, DROP):
- **WRITE, EOS edge:**
  - Set `bank_full[wr_bank]`.
  - Pulse `slice_ready` with `ready_bank` = `wr_bank` and `ready_slice` = `wslice_cnt` − 1, mod 128.
  - If `bank_full[~wr_bank]` is 0 (after same-cycle release): `wr_bank` ← ~`wr_bank`, stay in WRITE.
  - Otherwise go to DROP.
- **DROP:**
  - `ram_we` = 0; pixels are discarded.
  - On each EOS edge: if `bank_full[~wr_bank]` is 0, then `wr_bank` ← ~`wr_bank` and go to WRITE. Otherwise stay in DROP.
  - Every EOS edge seen in DROP is a dropped slice: increment `drop_cnt` (saturating at 255) and set `overflow`.
  - A release in mid-slice does not resume writing. Partial slices are never written.
- A pixel arriving in the same cycle as the EOS edge is the first pixel of the new slice. It is written to the new bank, or dropped if the state becomes DROP.

Reset values:
- Outputs: `ram_we`, `ram_waddr`, `ram_wdata`, `slice_ready`, `ready_bank`, `ready_slice`, `bank_full`, `overflow` and `drop_cnt` are all 0.
- Internal: state WRITE, `wr_bank` 0, `EOS_r` 0.
- Reset in mid-slice abandons the slice and both bank claims.

## Timing

- Write path: registered, 1-cycle latency. `pixel_valid` at cycle N gives `ram_we`/`ram_waddr`/`ram_wdata` at N+1.
- EOS: edge visible at cycle N (the `EOS` = 1, `EOS_r` = 0 cycle). `slice_ready`, `bank_full` and `wr_bank` update at N+1.
- Last pixel of a slice is at cycle N−1, so its write appears at N. The ready pulse therefore never precedes the last write of its bank.
- Release: `release_valid` at N clears `bank_full` at N+1.
- Throughput: one pixel per cycle, no backpressure.

## Configuration

- `SLICE_FB_WRITER_STATS_EN` defined: `drop_cnt` is an 8-bit saturating counter as described.
- Not defined: `drop_cnt` is tied to 0 and the counter is not built. `overflow` remains functional.

## Test plan

- **Full slice to bank 0.** After reset, feed 1920 valid pixels in raster order, then an EOS edge with `wslice_cnt` = 1.
  - Writes go to addresses 0x000..0x77F with µblock-major offsets; for example (bl 1, bc 2, pl 3, pc 4) → 924.
  - Then `slice_ready` pulses with bank 0 and slice 0, `bank_full` = 01, and the next pixel goes to 0x800.
- **Ping-pong.** Feed slices 1 and 2 with a release of bank 0 between them.
  - Banks alternate 0, 1, 0, and `ready_slice` increments.
  - `overflow` stays 0.
- **Overflow.** Feed three slices with no release.
  - The third slice produces no `ram_we`, and `overflow` = 1.
  - Releasing bank 0 in mid-slice does not resume writes. Writing resumes to bank 0 only after the next EOS edge.
  - `drop_cnt` = 1 with the macro defined, 0 without.
- **Simultaneous release and EOS.** Both banks are full and `release_valid` for bank 1 coincides with the EOS edge.
  - The switch succeeds, the state stays WRITE, and there is no drop.
- **EOS held high.** Hold `EOS` high for 5 cycles, for example while the FIFO is empty.
  - Exactly one `slice_ready` pulse and one bank swap.
- **Reset mid-slice.** Assert `nrst` low during a slice.
  - All outputs are 0 and `wr_bank` is 0.
  - After reset, the next pixel with zero coordinates writes address 0x000.
